// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if: pipeline-side bundle for the hazard controller.
//   master - pipeline/datapath: drives the ID/EX/MEM/WB register fields, consumes the controls.
//   slave  - hazard_ctrl: consumes register fields, drives stall/flush/forward controls.
// Signals: ID sources (id_rs1/2 + used flags), EX sources/dest + memread, MEM/WB dest + regwrite,
//          branch_taken; outputs pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush,
//          fwd_a, fwd_b, stall_busy.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
) ();
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_rs1_used;
  logic              id_rs2_used;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_memread;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_regwrite;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_regwrite;
  logic              branch_taken;

  logic              pc_stall;
  logic              ifid_stall;
  logic              idex_bubble;
  logic              ifid_flush;
  logic              idex_flush;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic              stall_busy;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rs1, ex_rs2, ex_rd, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, fwd_a, fwd_b, stall_busy
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rs1, ex_rs2, ex_rd, ex_memread,
           mem_rd, mem_regwrite, wb_rd, wb_regwrite, branch_taken,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, idex_flush, fwd_a, fwd_b, stall_busy
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use stall sequencing, branch flush and EX forwarding selects for the
// 5-stage pipeline.
// Ports:
//   i_clk  - core clock
//   i_rst  - synchronous active-high reset
//   io_hz  - hazard_ctrl_if.slave bundle (pipeline fields in, stall/flush/fwd controls out)
//   o_stall_cycles, o_flush_events - saturating performance counters, present only when
//                                    HAZARD_PERF_CNT_EN is defined.
// Stall/flush outputs are Mealy so they take effect in the cycle the hazard is seen.
module hazard_ctrl #(
  parameter int unsigned REG_AW   = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  hazard_ctrl_if.slave     io_hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
`endif
);

  if (LOAD_LAT < 1 || LOAD_LAT > 15 || CNT_W < 1 || REG_AW < 1) begin : g_param_check
    $error("hazard_ctrl: parameter out of range");
  end

  typedef enum logic [0:0] {StIdle, StLoadStall} state_e;

  // First stall cycle is spent in IDLE, so LOAD_STALL covers the remaining LOAD_LAT-1.
  localparam logic [3:0] LatM1 = 4'(LOAD_LAT - 1);

  state_e     r_state;
  logic [3:0] r_rem;

  logic       w_hit;
  logic       w_stall;
  logic       w_flush;
  logic       w_busy;
  logic [1:0] w_fwd_a;
  logic [1:0] w_fwd_b;

  function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src,
                                         input logic [REG_AW-1:0] mem_rd,
                                         input logic              mem_we,
                                         input logic [REG_AW-1:0] wb_rd,
                                         input logic              wb_we);
    logic [1:0] sel;
    sel = 2'b00;
    if (mem_we && (mem_rd != '0) && (mem_rd == src)) begin
      sel = 2'b10;
    end else if (wb_we && (wb_rd != '0) && (wb_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_hit = io_hz.ex_memread && (io_hz.ex_rd != '0) &&
                 ((io_hz.id_rs1_used && (io_hz.id_rs1 == io_hz.ex_rd)) ||
                  (io_hz.id_rs2_used && (io_hz.id_rs2 == io_hz.ex_rd)));

  always_comb begin
    w_stall = 1'b0;
    w_flush = 1'b0;
    w_busy  = 1'b0;
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!i_rst) begin
      w_fwd_a = fwd_sel(io_hz.ex_rs1, io_hz.mem_rd, io_hz.mem_regwrite,
                        io_hz.wb_rd, io_hz.wb_regwrite);
      w_fwd_b = fwd_sel(io_hz.ex_rs2, io_hz.mem_rd, io_hz.mem_regwrite,
                        io_hz.wb_rd, io_hz.wb_regwrite);
      if (io_hz.branch_taken) begin
        // Wrong-path squash overrides any stall, including an in-flight one.
        w_flush = 1'b1;
      end else if (r_state == StLoadStall) begin
        w_stall = 1'b1;
        w_busy  = 1'b1;
      end else if (w_hit) begin
        w_stall = 1'b1;
      end
    end
  end

  assign io_hz.pc_stall    = w_stall;
  assign io_hz.ifid_stall  = w_stall;
  assign io_hz.idex_bubble = w_stall;
  assign io_hz.ifid_flush  = w_flush;
  assign io_hz.idex_flush  = w_flush;
  assign io_hz.stall_busy  = w_busy;
  assign io_hz.fwd_a       = w_fwd_a;
  assign io_hz.fwd_b       = w_fwd_b;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_rem   <= 4'd0;
    end else if (io_hz.branch_taken) begin
      r_state <= StIdle;
      r_rem   <= 4'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_hit && (LOAD_LAT > 1)) begin
            r_state <= StLoadStall;
            r_rem   <= LatM1;
          end
        end
        StLoadStall: begin
          // New hits are ignored here: the count is never extended.
          r_rem <= r_rem - 4'd1;
          if (r_rem == 4'd1) begin
            r_state <= StIdle;
          end
        end
        default: begin
          r_state <= StIdle;
          r_rem   <= 4'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_flush_events;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (w_stall && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      end
      if (w_flush && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + CNT_W'(1);
      end
    end
  end

  assign o_stall_cycles = i_rst ? '0 : r_stall_cycles;
  assign o_flush_events = i_rst ? '0 : r_flush_events;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised hazard controller for the 5-stage pipelined RISC-V core, sitting beside the ID/EX/MEM/WB pipeline registers. It detects load-use hazards, holds the front end for a configurable number of cycles while a load completes, flushes wrong-path instructions on taken branches, and produces EX-stage forwarding selects. The stall sequencing is a small FSM, so memory latency can grow without re-plumbing the pipeline.

## Interface
Parameters:
- REG_AW, 5: register-address width.
- LOAD_LAT, 1: load-use stall cycles, range 1..15.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  core clock.
- rst  in  1  reset: synchronous and active-high, as fixed for this block.
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1  the ID instruction actually reads that source.
- ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX.
- ex_rd  in  REG_AW  destination of EX. ex_memread  in  1  EX is a load.
- mem_rd  in  REG_AW  destination of MEM. mem_regwrite  in  1  MEM writes the register file.
- wb_rd  in  REG_AW  destination of WB. wb_regwrite  in  1  WB writes the register file.
- branch_taken  in  1  branch/jump resolved taken in EX.
- pc_stall  out  1  hold the PC.
- ifid_stall  out  1  hold the IF/ID register.
- idex_bubble  out  1  load a NOP into ID/EX.
- ifid_flush  out  1  clear IF/ID.
- idex_flush  out  1  clear ID/EX.
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM.
- stall_busy  out  1  FSM is in LOAD_STALL.

## Operation
- hit = ex_memread & (ex_rd != 0) & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- FSM states are IDLE and LOAD_STALL. The remaining-cycle counter rem has width 4.
- In IDLE, when hit is true and branch_taken is false:
  - pc_stall, ifid_stall and idex_bubble are 1 this cycle.
  - If LOAD_LAT > 1, the next state is LOAD_STALL with rem = LOAD_LAT-1.
  - If LOAD_LAT = 1, the FSM stays in IDLE.
- In LOAD_STALL:
  - pc_stall, ifid_stall, idex_bubble and stall_busy are 1, independent of hit.
  - rem decrements each cycle. When rem == 1, the next state is IDLE.
- branch_taken has the highest priority:
  - ifid_flush and idex_flush are 1 and all stall outputs are 0 for that cycle.
  - The next state is IDLE. This applies in LOAD_STALL too, where the stall is aborted.
- Forwarding (combinational, per operand, shown for fwd_a with ex_rs1; fwd_b uses ex_rs2):
  - 10 if mem_regwrite & mem_rd != 0 & mem_rd == ex_rs1.
  - else 01 if wb_regwrite & wb_rd != 0 & wb_rd == ex_rs1.
  - else 00. MEM wins over WB.
- x0 never causes a hazard or a forward.

## Timing
- Stall and flush outputs are Mealy: they assert in the same cycle as hit or branch_taken, with no added latency.
- A load-use hazard yields exactly LOAD_LAT consecutive stall cycles, after which the dependent instruction leaves ID.
- A new hit arriving while in LOAD_STALL does not extend or restart the count.
- While rst is 1: all outputs are 0, fwd_a = fwd_b = 00, state is IDLE, rem is 0, counters are 0.
- rst asserted mid-stall aborts the stall on the next edge. Outputs are 0 from the cycle rst is sampled high.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs stall_cycles (CNT_W) and flush_events (CNT_W).
  - stall_cycles increments in every cycle pc_stall = 1.
  - flush_events increments in every cycle ifid_flush = 1.
  - Both saturate at all-ones and clear on rst.
- HAZARD_PERF_CNT_EN undefined: these ports and registers do not exist. All other behaviour is identical.

## Test plan
- LOAD_LAT=1: ex_memread=1, ex_rd=5, id_rs1=5, id_rs1_used=1 -> one cycle with pc_stall=ifid_stall=idex_bubble=1, stall_busy=0, then all 0.
- LOAD_LAT=3, same hit -> stall outputs 1 for exactly 3 cycles; stall_busy=1 on cycles 2-3; IDLE on cycle 4.
- LOAD_LAT=3: hit, then branch_taken=1 on the 2nd stall cycle -> that cycle has flushes=1 and stalls=0; the FSM is in IDLE next cycle.
- mem_rd=wb_rd=7 with both regwrite=1 and ex_rs1=7 -> fwd_a=10. With mem_regwrite=0 -> fwd_a=01. With ex_rd=0 on a load, or rd=0 -> no stall and fwd 00.
- hit with id_rs1_used=0 and only rs1 matching -> no stall. rst pulsed during LOAD_STALL -> outputs 0 and IDLE after the edge.
- With HAZARD_PERF_CNT_EN and CNT_W=2: 5 stall cycles -> stall_cycles saturates at 3. Two branch_taken cycles -> flush_events=2.
